// File: rtl/panda_stream_loader.sv
// panda_stream_loader: turns a start/base/length job plus a source word stream
// into paired address/data write beats through a small data FIFO.
// Optional build macro: PANDA_LOADER_BYTE_SWAP_EN (byte-reverse the data lane).
module panda_stream_loader #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ADDR_STRIDE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] nb_words,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] addr_data,
  output logic        addr_valid,
  input  logic        addr_ready,
  output logic [31:0] wdata_data,
  output logic        wdata_valid,
  input  logic        wdata_ready,
  output logic        wr_en,
  output logic        busy,
  output logic        done
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [15:0]        beats_q, beats_d;    // beats still to transfer
  logic [15:0]        pushes_q, pushes_d;  // source words still to accept
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        mem_q [FIFO_DEPTH];

  logic run, fifo_full, fifo_empty, push, pop, beat_valid;
  logic [31:0] head;

  // Lane ordering applied to the FIFO head word on its way out.
  function automatic logic [31:0] lane_order(input logic [31:0] w);
`ifdef PANDA_LOADER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Handshake and output decode; clear suppresses every handshake in its cycle.
  always_comb begin
    run        = (state_q == S_RUN);
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    in_ready   = run && !clear && !fifo_full && (pushes_q != 16'd0);
    beat_valid = run && !clear && !fifo_empty;
    push       = in_valid && in_ready;
    pop        = beat_valid && addr_ready && wdata_ready;
    head       = mem_q[rd_ptr_q];
    addr_valid  = beat_valid;
    wdata_valid = beat_valid;
    wr_en       = pop;
    addr_data   = addr_q;
    wdata_data  = fifo_empty ? 32'd0 : lane_order(head);
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
  end

  // Next-state logic for the job FSM, counters and FIFO pointers.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    pushes_d = pushes_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      state_d  = S_IDLE;
      addr_d   = '0;
      beats_d  = '0;
      pushes_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_d   = base_addr;
            beats_d  = nb_words;
            pushes_d = nb_words;
            state_d  = (nb_words == 16'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            pushes_d = pushes_q - 16'd1;
          end
          if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            addr_d   = addr_q + 32'(ADDR_STRIDE);
            beats_d  = beats_q - 16'd1;
            if (beats_q == 16'd1) state_d = S_DONE;
          end
          case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
          endcase
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      beats_q  <= '0;
      pushes_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      pushes_q <= pushes_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; no reset needed since the output is gated while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_panda_stream_loader.sv
// Testbench for panda_stream_loader: job table plus hand-written corner cases,
// every cycle compared against a queue-based reference model.
module tb_panda_stream_loader;

  localparam int DEPTH  = 4;
  localparam int STRIDE = 1;

  logic        clk = 1'b0;
  logic        reset, clear, start;
  logic [31:0] base_addr;
  logic [15:0] nb_words;
  logic [31:0] in_data;
  logic        in_valid, in_ready;
  logic [31:0] addr_data;
  logic        addr_valid, addr_ready;
  logic [31:0] wdata_data;
  logic        wdata_valid, wdata_ready;
  logic        wr_en, busy, done;

  panda_stream_loader #(.FIFO_DEPTH(DEPTH), .ADDR_STRIDE(STRIDE)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start),
    .base_addr(base_addr), .nb_words(nb_words),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .addr_data(addr_data), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .wdata_data(wdata_data), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .wr_en(wr_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: job phase, job descriptor, beats done, words taken, FIFO contents.
  int          mphase;  // 0 idle, 1 running, 2 finishing
  logic [31:0] mbase;
  int          mn, mk, mpushed;
  logic [31:0] mfifo[$];

  // Observations of the DUT.
  int          dut_beats;
  logic [31:0] dut_last_addr;
  int          dut_done_cnt;

  typedef struct {
    logic [31:0] base;
    logic [15:0] nb;
    int          vpct;
    int          rpct;
    int          exp_beats;
    logic [31:0] exp_last;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [31:0] ref_lane(input logic [31:0] w);
    logic [31:0] r;
    r = w;
`ifdef PANDA_LOADER_BYTE_SWAP_EN
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mphase = 0; mn = 0; mk = 0; mpushed = 0; mbase = '0;
    mfifo.delete();
  endtask

  // One clock: compare DUT against the model, advance the model, move to next negedge.
  task automatic cycle();
    logic e_run, e_in_ready, e_valid, e_wr;
    #1;
    if (reset) model_reset();
    e_run      = (mphase == 1) && !reset;
    e_in_ready = e_run && !clear && (mfifo.size() < DEPTH) && (mpushed < mn);
    e_valid    = e_run && !clear && (mfifo.size() > 0);
    e_wr       = e_valid && addr_ready && wdata_ready;
    chk("in_ready", {31'b0, in_ready}, {31'b0, e_in_ready});
    chk("addr_valid", {31'b0, addr_valid}, {31'b0, e_valid});
    chk("wdata_valid", {31'b0, wdata_valid}, {31'b0, e_valid});
    chk("wr_en", {31'b0, wr_en}, {31'b0, e_wr});
    chk("busy", {31'b0, busy}, {31'b0, (!reset && mphase != 0)});
    chk("done", {31'b0, done}, {31'b0, (!reset && mphase == 2)});
    if (e_valid) begin
      chk("addr_data", addr_data, mbase + 32'(mk * STRIDE));
      chk("wdata_data", wdata_data, ref_lane(mfifo[0]));
    end
    if (reset) begin
      chk("reset_addr_data", addr_data, 32'd0);
      chk("reset_wdata_data", wdata_data, 32'd0);
    end
    if (wr_en) begin dut_beats++; dut_last_addr = addr_data; end
    if (done) dut_done_cnt++;
    if (!reset) begin
      if (clear) model_reset();
      else if (mphase == 0) begin
        if (start) begin
          mbase = base_addr; mn = int'(nb_words); mk = 0; mpushed = 0;
          mphase = (nb_words == 16'd0) ? 2 : 1;
        end
      end else if (mphase == 1) begin
        if (e_wr) begin void'(mfifo.pop_front()); mk++; end
        if (e_in_ready && in_valid) begin mfifo.push_back(in_data); mpushed++; end
        if (e_wr && mk == mn) mphase = 2;
      end else mphase = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run until the model returns to idle, optionally randomizing the handshakes.
  task automatic drain(input int bound, input bit rnd, input int vpct, input int rpct);
    int g = 0;
    while (mphase != 0 && g < bound) begin
      if (rnd) begin
        in_valid    = ($urandom_range(0, 99) < vpct);
        in_data     = $urandom;
        addr_ready  = ($urandom_range(0, 99) < rpct);
        wdata_ready = ($urandom_range(0, 99) < rpct);
      end
      cycle();
      g++;
    end
    chk("job_ends_idle", {31'b0, busy}, 32'd0);
  endtask

  task automatic launch(input logic [31:0] b, input logic [15:0] n);
    dut_beats = 0; dut_done_cnt = 0;
    base_addr = b; nb_words = n; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; start = 1'b0; base_addr = '0; nb_words = '0;
    in_data = '0; in_valid = 1'b0; addr_ready = 1'b0; wdata_ready = 1'b0;
    model_reset();
    dut_beats = 0; dut_done_cnt = 0; dut_last_addr = '0;

    vecs[0] = '{32'h0000_0100, 16'd3,  100, 100, 3,  32'h0000_0102};
    vecs[1] = '{32'hFFFF_FFFF, 16'd2,  100, 100, 2,  32'h0000_0000};
    vecs[2] = '{32'h0000_0000, 16'd0,  100, 100, 0,  32'h0000_0000};
    vecs[3] = '{32'h0000_1000, 16'd7,  60,  50,  7,  32'h0000_1006};
    vecs[4] = '{32'hFFFF_FFFC, 16'd9,  70,  70,  9,  32'h0000_0004};
    vecs[5] = '{32'h0000_0040, 16'd20, 90,  30,  20, 32'h0000_0053};

    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Job table with randomized source and sink behaviour.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = $urandom; addr_ready = 1'b1; wdata_ready = 1'b1;
      launch(vecs[i].base, vecs[i].nb);
      drain(600, 1'b1, vecs[i].vpct, vecs[i].rpct);
      chk("job_beats", 32'(dut_beats), 32'(vecs[i].exp_beats));
      chk("job_done_pulses", 32'(dut_done_cnt), 32'd1);
      if (vecs[i].exp_beats > 0) chk("job_last_addr", dut_last_addr, vecs[i].exp_last);
      cycle();
    end

    // Sink stalled: FIFO fills, source is refused, nothing transfers.
    in_valid = 1'b1; in_data = 32'hA000_0000; addr_ready = 1'b1; wdata_ready = 1'b0;
    launch(32'h0000_0200, 16'd8);
    for (int i = 0; i < 10; i++) begin
      in_data = 32'hA000_0000 + 32'(i);
      cycle();
    end
    #1;
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    chk("stall_wr_en", {31'b0, wr_en}, 32'd0);
    chk("stall_valid", {31'b0, addr_valid}, 32'd1);
    chk("stall_head", wdata_data, ref_lane(32'hA000_0000));
    wdata_ready = 1'b1;
    for (int i = 0; i < 40 && mphase != 0; i++) begin
      if (in_ready) in_data = in_data + 32'd1;
      cycle();
    end
    chk("stall_beats", 32'(dut_beats), 32'd8);
    chk("stall_last_addr", dut_last_addr, 32'h0000_0207);

    // Lane ordering of a known word.
    in_valid = 1'b1; in_data = 32'h1122_3344; addr_ready = 1'b1; wdata_ready = 1'b0;
    launch(32'h0000_0300, 16'd1);
    cycle();
    #1;
`ifdef PANDA_LOADER_BYTE_SWAP_EN
    chk("lane_order", wdata_data, 32'h4433_2211);
`else
    chk("lane_order", wdata_data, 32'h1122_3344);
`endif
    wdata_ready = 1'b1;
    drain(20, 1'b0, 0, 0);

    // Clear after two of five beats, then a clean job.
    in_valid = 1'b1; addr_ready = 1'b1; wdata_ready = 1'b1; in_data = 32'hC0DE_0000;
    launch(32'h0000_0500, 16'd5);
    for (int g = 0; g < 50 && dut_beats < 2; g++) begin
      in_data = in_data + 32'd1;
      cycle();
    end
    chk("clear_at_beats", 32'(dut_beats), 32'd2);
    clear = 1'b1; start = 1'b1;
    cycle();
    clear = 1'b0; start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("clear_no_done", 32'(dut_done_cnt), 32'd0);
    chk("clear_idle", {31'b0, busy}, 32'd0);
    in_valid = 1'b1;
    launch(32'h0000_0600, 16'd4);
    drain(300, 1'b1, 80, 80);
    chk("after_clear_beats", 32'(dut_beats), 32'd4);
    chk("after_clear_last", dut_last_addr, 32'h0000_0603);

    // Reset asserted mid-job aborts without a done pulse.
    in_valid = 1'b1; addr_ready = 1'b1; wdata_ready = 1'b1;
    launch(32'h0000_0700, 16'd5);
    for (int g = 0; g < 50 && dut_beats < 2; g++) cycle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("reset_no_done", 32'(dut_done_cnt), 32'd0);
    in_valid = 1'b1;
    launch(32'h0000_0800, 16'd3);
    drain(300, 1'b1, 70, 70);
    chk("after_reset_beats", 32'(dut_beats), 32'd3);
    chk("after_reset_last", dut_last_addr, 32'h0000_0802);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
